// File: rtl/mem_responder.sv
// Memory-side responder for the LC-3b memory bus: word-addressed RAM with
// programmable wait states and a Data driver enabled only in a read's response cycle.
module mem_responder #(
    parameter int WIDTH       = 16,
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [19:0]      ADDR,
    inout  wire  [WIDTH-1:0] Data,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [1:0]       byte_en,
    output logic             mem_resp,
    output logic             addr_err,
    output logic             busy
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 err_q, err_d;
    logic                 wr_q, wr_d;
    logic [1:0]           be_q, be_d;
    logic [WIDTH-1:0]     wdata_q, wdata_d;
    logic [WIDTH-1:0]     rdata_q;
    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic                 commit;
    logic                 drive_en;

    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        err_d   = err_q;
        wr_d    = wr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (mem_read ^ mem_write) begin
                    addr_d  = ADDR[ADDR_BITS-1:0];
                    err_d   = |ADDR[19:ADDR_BITS];
                    wr_d    = mem_write;
                    be_d    = byte_en;
                    wdata_d = Data;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                // A released request cancels the access even on the final wait edge.
                if (!mem_read && !mem_write) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = S_RESP;
                end
            end
            S_RESP: state_d = S_HOLD;
            S_HOLD: begin
                if (!mem_read && !mem_write) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Captured fields are read through _d so a zero-wait access commits on its capture edge.
    assign commit = (state_d == S_RESP) && (state_q != S_RESP);

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            if (commit && !wr_d) rdata_q <= err_d ? '0 : mem_q[addr_d];
        end
    end

    // NOTE: the RAM array is deliberately never reset; contents survive Reset.
    always_ff @(posedge Clk) begin
        if (!Reset && commit && wr_d && !err_d) begin
            if (be_d[0]) mem_q[addr_d][7:0]       <= wdata_d[7:0];
            if (be_d[1]) mem_q[addr_d][WIDTH-1:8] <= wdata_d[WIDTH-1:8];
        end
    end

    always_comb begin
        mem_resp = (state_q == S_RESP);
        addr_err = (state_q == S_RESP) && err_q;
        busy     = (state_q != S_IDLE);
        drive_en = (state_q == S_RESP) && !wr_q;
    end

    assign Data = drive_en ? rdata_q : 'z;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against an array-based memory
// model with cycle-exact expectations for response timing, bus ownership and aborts.
module tb_mem_responder;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] addr;
    wire  [15:0] data_bus;
    logic [15:0] bus_val;
    logic        bus_en;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  byte_en;
    logic        mem_resp;
    logic        addr_err;
    logic        busy;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] ref_mem [1024];

    always #5 clk = ~clk;

    // The bench plays the datapath side of the bus: it drives except when a read response is due.
    assign data_bus = bus_en ? bus_val : 'z;

    mem_responder #(
        .WIDTH      (16),
        .ADDR_BITS  (10),
        .WAIT_STATES(WS)
    ) dut (
        .Clk      (clk),
        .Reset    (reset),
        .ADDR     (addr),
        .Data     (data_bus),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .byte_en  (byte_en),
        .mem_resp (mem_resp),
        .addr_err (addr_err),
        .busy     (busy)
    );

    // One complete access, started at a negedge with the DUT idle; request held extra_hold
    // cycles past the response cycle.
    task automatic access(input string name, input bit is_wr, input logic [19:0] a,
                          input logic [15:0] wd, input logic [1:0] be, input int extra_hold);
        bit          err;
        logic [15:0] exp_rd;
        err    = (a[19:10] != 10'd0);
        exp_rd = err ? 16'h0000 : ref_mem[a[9:0]];
        addr      = a;
        byte_en   = be;
        mem_read  = !is_wr;
        mem_write = is_wr;
        bus_en    = 1'b1;
        bus_val   = is_wr ? wd : 16'($urandom);
        if (is_wr && !err) begin
            if (be[0]) ref_mem[a[9:0]][7:0]  = wd[7:0];
            if (be[1]) ref_mem[a[9:0]][15:8] = wd[15:8];
        end
        for (int k = 1; k <= WS + 1; k++) begin
            @(negedge clk);
            vectors++;
            if (mem_resp !== 1'(k == WS + 1)) begin
                miscompares++;
                $display("FAIL %s mem_resp cycle %0d got %b want %b", name, k, mem_resp, k == WS + 1);
            end
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s busy cycle %0d got %b want 1", name, k, busy);
            end
            vectors++;
            if (addr_err !== 1'((k == WS + 1) && err)) begin
                miscompares++;
                $display("FAIL %s addr_err cycle %0d got %b want %b", name, k, addr_err,
                         (k == WS + 1) && err);
            end
            vectors++;
            if (k == WS + 1 && !is_wr) begin
                if (data_bus !== exp_rd) begin
                    miscompares++;
                    $display("FAIL %s read data got %h want %h", name, data_bus, exp_rd);
                end
            end else if (data_bus !== bus_val) begin
                miscompares++;
                $display("FAIL %s bus contention cycle %0d got %h want %h", name, k, data_bus, bus_val);
            end
            if (!is_wr && k == WS) bus_en = 1'b0;
            if (k == WS + 1) begin
                bus_en  = 1'b1;
                bus_val = 16'($urandom);
            end
        end
        for (int h = 1; h <= extra_hold; h++) begin
            @(negedge clk);
            vectors++;
            if (mem_resp !== 1'b0 || busy !== 1'b1 || data_bus !== bus_val) begin
                miscompares++;
                $display("FAIL %s hold %0d resp/busy/bus got %b/%b/%h want 0/1/%h",
                         name, h, mem_resp, busy, data_bus, bus_val);
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (extra_hold == 0) begin
            @(negedge clk);
            vectors++;
            if (mem_resp !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s hold state resp/busy got %b/%b want 0/1", name, mem_resp, busy);
            end
        end
        @(negedge clk);
        vectors++;
        if (mem_resp !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s release resp/busy got %b/%b want 0/0", name, mem_resp, busy);
        end
    endtask

    // Starts a request and drops it after the first wait cycle; nothing may complete.
    task automatic aborted(input string name, input bit is_wr, input logic [19:0] a,
                           input logic [15:0] wd);
        addr      = a;
        byte_en   = 2'b11;
        mem_read  = !is_wr;
        mem_write = is_wr;
        bus_val   = wd;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || mem_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL %s wait busy/resp got %b/%b want 1/0", name, busy, mem_resp);
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || mem_resp !== 1'b0) begin
                miscompares++;
                $display("FAIL %s after drop %0d busy/resp got %b/%b want 0/0", name, k, busy, mem_resp);
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        bus_en    = 1'b1;
        bus_val   = 16'h5A5A;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || mem_resp !== 1'b0 || addr_err !== 1'b0 || data_bus !== bus_val) begin
                miscompares++;
                $display("FAIL reset busy/resp/err/bus got %b/%b/%b/%h want 0/0/0/%h",
                         busy, mem_resp, addr_err, data_bus, bus_val);
            end
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill();
        for (int a = 0; a < 16; a++) access("fill", 1'b1, 20'(a), 16'($urandom), 2'b11, 0);
    endtask

    task automatic test_basic();
        access("wr_beef", 1'b1, 20'h00012, 16'hBEEF, 2'b11, 0);
        access("rd_beef", 1'b0, 20'h00012, 16'h0000, 2'b00, 0);
    endtask

    task automatic test_byte_enables();
        access("wr_be01", 1'b1, 20'h00012, 16'h1234, 2'b01, 1);
        access("rd_be34", 1'b0, 20'h00012, 16'h0000, 2'b10, 0);
        vectors++;
        if (ref_mem[10'h012] !== 16'hBE34) begin
            miscompares++;
            $display("FAIL model be01 merge got %h want be34", ref_mem[10'h012]);
        end
        access("wr_be00", 1'b1, 20'h00012, 16'hFFFF, 2'b00, 0);
        access("rd_be00", 1'b0, 20'h00012, 16'h0000, 2'b11, 0);
    endtask

    task automatic test_abort();
        aborted("abort_rd", 1'b0, 20'h00040, 16'h0000);
        aborted("abort_wr", 1'b1, 20'h00003, ~ref_mem[3]);
        access("rd_after_abort", 1'b0, 20'h00003, 16'h0000, 2'b11, 0);
    endtask

    task automatic test_hold_and_conflict();
        access("long_hold", 1'b0, 20'h00012, 16'h0000, 2'b11, 4);
        addr      = 20'h00007;
        mem_read  = 1'b1;
        mem_write = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || mem_resp !== 1'b0) begin
                miscompares++;
                $display("FAIL conflict %0d busy/resp got %b/%b want 0/0", k, busy, mem_resp);
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_range();
        access("rd_oob", 1'b0, 20'h10000, 16'h0000, 2'b11, 0);
        access("wr_oob", 1'b1, 20'h10000, 16'hDEAD, 2'b11, 0);
        access("rd_ram0", 1'b0, 20'h00000, 16'h0000, 2'b11, 0);
    endtask

    task automatic test_reset_mid_wait();
        addr      = 20'h00005;
        byte_en   = 2'b11;
        mem_write = 1'b1;
        bus_val   = ~ref_mem[5];
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || mem_resp !== 1'b0 || data_bus !== bus_val) begin
                miscompares++;
                $display("FAIL reset_mid_wait busy/resp/bus got %b/%b/%h want 0/0/%h",
                         busy, mem_resp, data_bus, bus_val);
            end
        end
        mem_write = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        access("rd_after_reset", 1'b0, 20'h00005, 16'h0000, 2'b11, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [19:0] a;
            a = 20'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) a[19:10] = 10'($urandom_range(1, 1023));
            access("random", 1'($urandom_range(0, 1)), a, 16'($urandom), 2'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        reset     = 1'b1;
        addr      = '0;
        byte_en   = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        bus_en    = 1'b1;
        bus_val   = '0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_basic();
        test_byte_enables();
        test_abort();
        test_hold_and_conflict();
        test_range();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
